// File: rtl/interlacer_pkg.sv
// Shared types and constants for the progressive-to-interlaced converter.
package interlacer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISCARD,
    CTRL,
    VHDR,
    PASS,
    FLUSH,
    PAD
  } state_t;

  typedef enum logic {
    F0 = 1'b0,
    F1 = 1'b1
  } field_t;

  localparam logic [3:0] CTRL_TYPE  = 4'hF;
  localparam logic [3:0] VIDEO_TYPE = 4'h0;
  localparam logic [3:0] ILACE_F0   = 4'b1000;
  localparam logic [3:0] ILACE_F1   = 4'b1100;
  localparam logic [3:0] LAST_CTRL_BEAT = 4'd9;

  // Nibble carried by each beat of the regenerated control packet.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0]  beat,
                                             input logic [15:0] width,
                                             input logic [15:0] lines,
                                             input field_t      field);
    case (beat)
      4'd0:    return CTRL_TYPE;
      4'd1:    return width[15:12];
      4'd2:    return width[11:8];
      4'd3:    return width[7:4];
      4'd4:    return width[3:0];
      4'd5:    return lines[15:12];
      4'd6:    return lines[11:8];
      4'd7:    return lines[7:4];
      4'd8:    return lines[3:0];
      default: return (field == F1) ? ILACE_F1 : ILACE_F0;
    endcase
  endfunction

endpackage

// File: rtl/interlacer_avst_out_reg.sv
// Single-stage Avalon-ST source register: loads when empty or draining, holds while stalled.
module avst_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_sop,
  input  logic                  load_eop,
  output logic                  can_load,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_sop,
  output logic                  dout_eop
);

  assign can_load = dout_ready || !dout_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else if (can_load) begin
      dout_valid <= load;
      if (load) begin
        dout_data <= load_data;
        dout_sop  <= load_sop;
        dout_eop  <= load_eop;
      end
    end
  end

endmodule

// File: rtl/interlacer.sv
// Progressive frame in, alternating F0/F1 fields out, each with a regenerated control packet.
// Optional INTERLACER_STATS_EN adds fields_out and short_frames counters.
module interlacer
  import interlacer_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  localparam int DATA_WIDTH      = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket
`ifdef INTERLACER_STATS_EN
  ,
  output logic [15:0]           fields_out,
  output logic [15:0]           short_frames
`endif
);

  localparam logic [15:0] LAST_COL   = 16'(WIDTH - 1);
  localparam logic [15:0] HALF_LINES = 16'(HEIGHT / 2);

  state_t                state, next_state;
  field_t                field;
  logic [3:0]            beat;
  logic [15:0]           col, row;
  logic                  kept, last_kept, can_load, din_ready_int, din_accept;
  logic                  load, load_sop, load_eop;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  advance, skip_row, field_done;

  assign kept       = (row[0] == field);
  assign last_kept  = kept && (col == LAST_COL) &&
                      (row == ((field == F1) ? 16'(HEIGHT - 1) : 16'(HEIGHT - 2)));
  // Reset gates ready directly so the sink stalls in the same cycle reset is asserted.
  assign din_ready  = reset && din_ready_int;
  assign din_accept = din_valid && din_ready_int;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (din_valid && din_startofpacket) begin
          if (din_data[3:0] == VIDEO_TYPE) next_state = CTRL;
          else if (!din_endofpacket)       next_state = DISCARD;
        end
      DISCARD, FLUSH:
        if (din_valid && din_endofpacket) next_state = IDLE;
      CTRL:
        if (can_load && beat == LAST_CTRL_BEAT) next_state = VHDR;
      VHDR:
        if (can_load) next_state = PASS;
      PASS:
        if (din_valid && din_startofpacket) next_state = PAD;
        else if (din_accept) begin
          if (last_kept)            next_state = din_endofpacket ? IDLE : FLUSH;
          else if (din_endofpacket) next_state = PAD;
        end
      PAD:
        if (can_load && last_kept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    din_ready_int = 1'b0;
    load          = 1'b0;
    load_data     = '0;
    load_sop      = 1'b0;
    load_eop      = 1'b0;
    case (state)
      IDLE, DISCARD, FLUSH: din_ready_int = 1'b1;
      CTRL: begin
        load      = can_load;
        load_data = DATA_WIDTH'(ctrl_nibble(beat, 16'(WIDTH), HALF_LINES, field));
        load_sop  = (beat == 4'd0);
        load_eop  = (beat == LAST_CTRL_BEAT);
      end
      VHDR: begin
        load      = can_load;
        load_data = DATA_WIDTH'(VIDEO_TYPE);
        load_sop  = 1'b1;
      end
      // A new sop is left unconsumed so IDLE can pick it up after padding.
      PASS: begin
        if (din_valid && din_startofpacket) din_ready_int = 1'b0;
        else if (kept)                      din_ready_int = can_load;
        else                                din_ready_int = 1'b1;
        load      = din_valid && !din_startofpacket && kept && can_load;
        load_data = din_data;
        load_eop  = last_kept;
      end
      PAD: begin
        load     = can_load && kept;
        load_eop = last_kept;
      end
      default: ;
    endcase
  end

  assign advance    = ((state == PASS) && din_accept) || ((state == PAD) && kept && can_load);
  assign skip_row   = (state == PAD) && !kept;
  assign field_done = ((state == PASS) && din_accept && last_kept && din_endofpacket) ||
                      ((state == FLUSH) && din_valid && din_endofpacket) ||
                      ((state == PAD) && can_load && last_kept);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      field <= F0;
      beat  <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      if (field_done) field <= (field == F0) ? F1 : F0;
      if (state == CTRL && can_load) beat <= (beat == LAST_CTRL_BEAT) ? 4'd0 : beat + 4'd1;
      if (state == VHDR) begin
        col <= '0;
        row <= '0;
      end else if (skip_row) begin
        col <= '0;
        row <= row + 16'd1;
      end else if (advance) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end
      end
    end
  end

`ifdef INTERLACER_STATS_EN
  logic pad_entry;
  assign pad_entry = (state != PAD) && (next_state == PAD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fields_out   <= '0;
      short_frames <= '0;
    end else begin
      if (field_done) fields_out <= fields_out + 16'd1;
      if (pad_entry && short_frames != 16'hFFFF) short_frames <= short_frames + 16'd1;
    end
  end
`endif

  avst_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_sop   (load_sop),
    .load_eop   (load_eop),
    .can_load   (can_load),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_sop   (dout_startofpacket),
    .dout_eop   (dout_endofpacket)
  );

endmodule

// File: tb/tb_interlacer.sv
// Directed bench for interlacer with a 4x4 frame: field order, stalls, short/long frames, reset.
module tb_interlacer;

  localparam int W = 4;
  localparam int H = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din_data = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       din_startofpacket = 1'b0;
  logic       din_endofpacket = 1'b0;
  logic [7:0] dout_data;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       dout_startofpacket;
  logic       dout_endofpacket;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [9:0] rcv_q[$];
  logic [9:0] exp_q[$];
  bit         rand_ready = 1'b0;
  bit         stalled = 1'b0;
  logic [9:0] stall_word = '0;

  interlacer #(
    .SYMBOLS_PER_BEAT (1),
    .BITS_PER_SYMBOL  (8),
    .WIDTH            (W),
    .HEIGHT           (H)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .din_data           (din_data),
    .din_valid          (din_valid),
    .din_ready          (din_ready),
    .din_startofpacket  (din_startofpacket),
    .din_endofpacket    (din_endofpacket),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Collects output transfers and checks that a stalled beat stays put.
  always @(negedge clock) begin
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        checkOutput("hold", 16'({dout_valid, dout_startofpacket, dout_endofpacket, dout_data}),
                    16'({1'b1, stall_word}));
      if (dout_valid && dout_ready)
        rcv_q.push_back({dout_startofpacket, dout_endofpacket, dout_data});
      stalled    = dout_valid && !dout_ready;
      stall_word = {dout_startofpacket, dout_endofpacket, dout_data};
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] data, input logic sop, input logic eop, input int gap);
    bit accepted;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    din_data          = data;
    din_startofpacket = sop;
    din_endofpacket   = eop;
    din_valid         = 1'b1;
    accepted          = 1'b0;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clock);
      if (din_ready) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    din_valid         = 1'b0;
    din_startofpacket = 1'b0;
    din_endofpacket   = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 16'(accepted), 16'd1);
  endtask

  task automatic send_ctrl_in(input int max_gap);
    applyStimulus(8'h0F, 1'b1, 1'b0, 0);
    for (int i = 1; i < 10; i++)
      applyStimulus(8'h03, 1'b0, (i == 9), $urandom_range(0, max_gap));
  endtask

  task automatic send_video(input int n, input int max_gap);
    applyStimulus(8'h00, 1'b1, 1'b0, $urandom_range(0, max_gap));
    for (int p = 0; p < n; p++)
      applyStimulus(8'(p), 1'b0, (p == n - 1), $urandom_range(0, max_gap));
  endtask

  task automatic expect_ctrl(input bit f1);
    exp_q.push_back({2'b10, 8'h0F});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h04});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'h02});
    exp_q.push_back({2'b01, f1 ? 8'h0C : 8'h08});
    exp_q.push_back({2'b10, 8'h00});
  endtask

  task automatic expect_pixels(input int first_a, input int first_b, input int n_b);
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, 8'(first_a + i)});
    for (int i = 0; i < n_b; i++) exp_q.push_back({1'b0, (i == 3), 8'(first_b + i)});
  endtask

  task automatic check_queues(input string tag);
    for (int i = 0; i < 400 && rcv_q.size() < exp_q.size(); i++) begin
      @(posedge clock);
      #1;
    end
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    checkOutput({tag, "_count"}, 16'(rcv_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < rcv_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s[%0d]", tag, i), 16'(rcv_q[i]), 16'(exp_q[i]));
    rcv_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_din_ready", 16'(din_ready), 16'd0);
    checkOutput("reset_dout_valid", 16'(dout_valid), 16'd0);
    checkOutput("reset_dout_sop", 16'(dout_startofpacket), 16'd0);
    checkOutput("reset_dout_eop", 16'(dout_endofpacket), 16'd0);
    checkOutput("reset_dout_data", 16'(dout_data), 16'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("idle_ready", 16'(din_ready), 16'd1);

    // Test 1: first frame gives F0 with even lines.
    send_ctrl_in(0);
    send_video(16, 0);
    expect_ctrl(1'b0);
    expect_pixels(0, 8, 4);
    check_queues("t1_f0");

    // Test 2: second frame gives F1 with odd lines.
    send_ctrl_in(0);
    send_video(16, 0);
    expect_ctrl(1'b1);
    expect_pixels(4, 12, 4);
    check_queues("t2_f1");

    // Test 3: random backpressure and input gaps, F0 then F1.
    rand_ready = 1'b1;
    send_ctrl_in(2);
    send_video(16, 2);
    expect_ctrl(1'b0);
    expect_pixels(0, 8, 4);
    check_queues("t3_f0");
    send_ctrl_in(2);
    send_video(16, 2);
    expect_ctrl(1'b1);
    expect_pixels(4, 12, 4);
    check_queues("t3_f1");
    rand_ready = 1'b0;
    dout_ready = 1'b1;

    // Test 4: short F0 frame ending at pixel 9 is padded, next frame is F1.
    send_ctrl_in(0);
    send_video(10, 0);
    expect_ctrl(1'b0);
    expect_pixels(0, 8, 2);
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 8'h00});
    check_queues("t4_short");
    send_ctrl_in(0);
    send_video(16, 0);
    expect_ctrl(1'b1);
    expect_pixels(4, 12, 4);
    check_queues("t4_next_f1");

    // Test 5: long F0 frame, extra pixels flushed.
    send_ctrl_in(0);
    send_video(20, 0);
    expect_ctrl(1'b0);
    expect_pixels(0, 8, 4);
    check_queues("t5_long");

    // Test 6: F1 frame accepted after the long one, then reset mid-PASS.
    send_ctrl_in(0);
    applyStimulus(8'h00, 1'b1, 1'b0, 0);
    for (int p = 0; p < 4; p++) applyStimulus(8'(p), 1'b0, 1'b0, 0);
    dout_ready = 1'b0;
    applyStimulus(8'd4, 1'b0, 1'b0, 0);
    expect_ctrl(1'b1);
    check_queues("t6_pre");
    checkOutput("t6_stuck_valid", 16'(dout_valid), 16'd1);
    checkOutput("t6_stuck_data", 16'(dout_data), 16'd4);
    reset = 1'b0;
    #1;
    checkOutput("t6_reset_valid", 16'(dout_valid), 16'd0);
    checkOutput("t6_reset_ready", 16'(din_ready), 16'd0);
    checkOutput("t6_reset_eop", 16'(dout_endofpacket), 16'd0);
    dout_ready = 1'b1;
    @(posedge clock);
    #1;
    rcv_q.delete();
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_ctrl_in(0);
    send_video(16, 0);
    expect_ctrl(1'b0);
    expect_pixels(0, 8, 4);
    check_queues("t6_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
